// File: rtl/dma_sched_pkg.sv
// Shared constants and types for the DMA frame scheduler: DMA register map,
// FSM state encoding and the frame-size validation rule.
package dma_sched_pkg;

    localparam logic [4:0] REG_START_ADDR = 5'h00;
    localparam logic [4:0] REG_WORDS      = 5'h04;
    localparam logic [4:0] REG_ENABLE     = 5'h08;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_WORDS,
        ST_WR_EN,
        ST_RUN,
        ST_WR_SWAP,
        ST_WR_DIS
    } state_t;

    // A frame must be a non-zero whole number of DMA bursts.
    function automatic logic words_ok(input logic [29:0] words, input int unsigned burst);
        return (words != '0) && ((words % 30'(burst)) == '0);
    endfunction

endpackage

// File: rtl/avl_mm_write_master.sv
// Single-outstanding Avalon-MM write master. A request is loaded whenever the
// bus is free or the current write is being accepted, so writes can stream.
module avl_mm_write_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    output logic        done,
    output logic [4:0]  ctrl_address,
    output logic        ctrl_write,
    output logic [31:0] ctrl_writedata,
    output logic [3:0]  ctrl_byteenable,
    input  logic        ctrl_waitrequest
);

    assign done            = ctrl_write & ~ctrl_waitrequest;
    assign ctrl_byteenable = 4'hF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_write     <= 1'b0;
            ctrl_address   <= '0;
            ctrl_writedata <= '0;
        end else if (!ctrl_write || !ctrl_waitrequest) begin
            ctrl_write <= req;
            if (req) begin
                ctrl_address   <= addr;
                ctrl_writedata <= data;
            end
        end
    end

endmodule

// File: rtl/dma_frame_scheduler.sv
// Frame-by-frame sequencer for the AXI-to-stream DMA: programs base/words/enable,
// tracks frame ends on the output stream, swaps ping-pong buffers and stops cleanly.
module dma_frame_scheduler
    import dma_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 24,
    parameter int BURST_SIZE      = 128,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_enable,
    input  logic [ADDR_WIDTH-1:0]      cfg_buf0_addr,
    input  logic [ADDR_WIDTH-1:0]      cfg_buf1_addr,
    input  logic [29:0]                cfg_words,
    input  logic                       cfg_swap_req,
    output logic [4:0]                 ctrl_address,
    output logic                       ctrl_write,
    output logic [31:0]                ctrl_writedata,
    output logic [3:0]                 ctrl_byteenable,
    input  logic                       ctrl_waitrequest,
    input  logic                       st_valid,
    input  logic                       st_ready,
    input  logic                       st_endofpacket,
    output logic                       busy,
    output logic                       active_buf,
    output logic                       frame_done,
    output logic                       swap_done,
    output logic                       cfg_error,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    state_t      state_q, state_d;
    logic        wr_req, wr_done;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [29:0] words_q;
    logic        swap_pending, err_lock;
    logic        fe, fe_cnt, start_go, start_bad, swap_acc;

    assign fe        = st_valid & st_ready & st_endofpacket;
    assign fe_cnt    = fe & (state_q inside {ST_RUN, ST_WR_SWAP, ST_WR_DIS});
    assign start_go  = (state_q == ST_IDLE) & cfg_enable & ~err_lock & words_ok(cfg_words, BURST_SIZE);
    assign start_bad = (state_q == ST_IDLE) & cfg_enable & ~err_lock & ~words_ok(cfg_words, BURST_SIZE);
    assign swap_acc  = (state_q == ST_WR_SWAP) & wr_done;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_go) state_d = ST_WR_ADDR;
            ST_WR_ADDR:  if (wr_done)  state_d = ST_WR_WORDS;
            ST_WR_WORDS: if (wr_done)  state_d = ST_WR_EN;
            ST_WR_EN:    if (wr_done)  state_d = ST_RUN;
            ST_RUN: begin
                // Disable takes priority; a pending swap survives the stop.
                if (fe && !cfg_enable)   state_d = ST_WR_DIS;
                else if (fe && swap_pending) state_d = ST_WR_SWAP;
            end
            ST_WR_SWAP:  if (wr_done)  state_d = ST_RUN;
            ST_WR_DIS:   if (wr_done)  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Writes are issued on the cycle the FSM enters a write state, so the
    // master register already holds the next write when the previous completes.
    always_comb begin
        wr_req  = 1'b0;
        wr_addr = REG_START_ADDR;
        wr_data = '0;
        case (state_q)
            ST_IDLE: if (start_go) begin
                wr_req  = 1'b1;
                wr_data = 32'(active_buf ? cfg_buf1_addr : cfg_buf0_addr);
            end
            ST_WR_ADDR: if (wr_done) begin
                wr_req  = 1'b1;
                wr_addr = REG_WORDS;
                wr_data = {2'b00, words_q};
            end
            ST_WR_WORDS: if (wr_done) begin
                wr_req  = 1'b1;
                wr_addr = REG_ENABLE;
                wr_data = 32'd1;
            end
            ST_RUN: if (fe && !cfg_enable) begin
                wr_req  = 1'b1;
                wr_addr = REG_ENABLE;
            end else if (fe && swap_pending) begin
                wr_req  = 1'b1;
                wr_data = 32'(active_buf ? cfg_buf0_addr : cfg_buf1_addr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_buf   <= 1'b0;
            frame_done   <= 1'b0;
            swap_done    <= 1'b0;
            cfg_error    <= 1'b0;
            frame_count  <= '0;
            swap_pending <= 1'b0;
            err_lock     <= 1'b0;
            words_q      <= '0;
        end else begin
            frame_done <= fe_cnt;
            swap_done  <= swap_acc;
            cfg_error  <= start_bad;
            // After a rejected start, wait for enable to drop before retrying.
            if (start_bad)        err_lock <= 1'b1;
            else if (!cfg_enable) err_lock <= 1'b0;
            if (start_go) begin
                words_q     <= cfg_words;
                frame_count <= '0;
            end else if (fe_cnt) begin
                frame_count <= frame_count + 1'b1;
            end
            if (swap_acc) active_buf <= ~active_buf;
            if (cfg_swap_req)  swap_pending <= 1'b1;
            else if (swap_acc) swap_pending <= 1'b0;
        end
    end

    avl_mm_write_master u_wr (
        .clk              (clk),
        .rst              (rst),
        .req              (wr_req),
        .addr             (wr_addr),
        .data             (wr_data),
        .done             (wr_done),
        .ctrl_address     (ctrl_address),
        .ctrl_write       (ctrl_write),
        .ctrl_writedata   (ctrl_writedata),
        .ctrl_byteenable  (ctrl_byteenable),
        .ctrl_waitrequest (ctrl_waitrequest)
    );

endmodule
